// File: rtl/nbit_rca_pkg.sv
// nbit_rca_pkg -- shared constants and types for the nbit_rca adder slice.
//
// Contents:
//   NBIT_RCA_DEFAULT_W : default operand width (8)
//   NBIT_RCA_MAX_W     : widest legal operand width (64)
//   carry_vec_t        : internal carry vector, sized for the widest adder;
//                        an N-bit instance uses bits [N:0] of it.
package nbit_rca_pkg;

  localparam int NBIT_RCA_DEFAULT_W = 8;
  localparam int NBIT_RCA_MAX_W     = 64;

  // Bit 0 is the carry-in, bit i+1 is the carry out of full adder i.
  typedef logic [NBIT_RCA_MAX_W:0] carry_vec_t;

endpackage : nbit_rca_pkg

// File: rtl/rca_full_adder.sv
// rca_full_adder -- one-bit full adder cell of the ripple-carry chain.
//
// Ports:
//   a, b : operand bits (input)
//   ci   : carry in (input)
//   s    : sum bit (output)
//   co   : carry out, majority of a/b/ci (output)
//
// Purely combinational.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : rca_full_adder

// File: rtl/nbit_rca.sv
// nbit_rca -- N-bit ripple-carry adder with a registered result stage.
//
// The sum is formed by a strict chain of N rca_full_adder cells (no
// lookahead, no '+' inference) and captured on the rising clock edge,
// giving one cycle of latency and one addition per cycle.
//
// Parameters:
//   N     : operand / sum width, 1..64 (default 8)
//
// Ports:
//   clk   : rising-edge clock (input)
//   rst_n : asynchronous active-low reset, clears all outputs (input)
//   a, b  : N-bit operands, unsigned or two's complement (input)
//   cin   : carry into bit 0 (input)
//   s     : registered sum, (a + b + cin) mod 2^N (output)
//   cout  : registered carry out of bit N-1 (output)
//   ovf   : registered signed overflow (output, only with NBIT_RCA_OVF_EN)
//
// Build option:
//   NBIT_RCA_OVF_EN : when defined, adds the ovf port and its register.
module nbit_rca
  import nbit_rca_pkg::*;
#(
  parameter int N = NBIT_RCA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
`ifdef NBIT_RCA_OVF_EN
  output logic         cout,
  output logic         ovf
`else
  output logic         cout
`endif
);

  if (N < 1 || N > NBIT_RCA_MAX_W) begin : g_bad_width
    $error("nbit_rca: N=%0d outside legal range 1..%0d", N, NBIT_RCA_MAX_W);
  end

  carry_vec_t   carry_p0;
  logic [N-1:0] sum_p0;

  // Stage 0: combinational ripple chain
  assign carry_p0[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_p0[i]),
      .s  (sum_p0[i]),
      .co (carry_p0[i+1])
    );
  end

  // The shared carry type is sized for the widest adder; tie off the bits
  // above this instance's chain so nothing is left floating.
  if (N < NBIT_RCA_MAX_W) begin : g_carry_tie
    logic unused_carry_hi;
    assign carry_p0[NBIT_RCA_MAX_W:N+1] = '0;
    assign unused_carry_hi = ^carry_p0[NBIT_RCA_MAX_W:N+1];
  end

  // Stage 1: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum_p0;
      cout <= carry_p0[N];
    end
  end

`ifdef NBIT_RCA_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For N = 1 the carry into the sign bit is cin itself (carry_p0[0]).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      ovf <= carry_p0[N] ^ carry_p0[N-1];
    end
  end
`endif

endmodule : nbit_rca

// File: tb/tb_nbit_rca.sv
// tb_nbit_rca -- self-checking bench for nbit_rca at N = 8.
//
// Directed vectors, an asynchronous reset case and 10,000 back-to-back
// random vectors, all compared with an arithmetic reference model.
// Build option NBIT_RCA_OVF_EN also enables the ovf checks.
module tb_nbit_rca;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
`ifdef NBIT_RCA_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  nbit_rca #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
`ifdef NBIT_RCA_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. {ovf, cout, s}.
  function automatic logic [N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic cv);
    int          us;
    int          ss;
    logic        o;
    logic [N:0]  u;
    us = int'(av) + int'(bv) + int'(cv);
    ss = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    o  = (ss > 127) || (ss < -128);
    u  = us[N:0];
    return {o, u};
  endfunction

  task automatic check_out(input string tag, input logic [N+1:0] exp);
    chk({tag, "_sum"}, {55'd0, cout, s}, {55'd0, exp[N:0]});
`ifdef NBIT_RCA_OVF_EN
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, exp[N+1]});
`endif
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic cv);
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
    @(posedge clk);
    #1;
    check_out(tag, model(av, bv, cv));
  endtask

  logic [N+1:0] exp_prev;

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Outputs held at zero across clock edges while reset is low.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", '0);

    @(negedge clk);
    rst_n = 1'b1;

    run_vec("v23_32", 8'h23, 8'h32, 1'b1);
    run_vec("vab_00", 8'hAB, 8'h00, 1'b1);
    run_vec("vff_00", 8'hFF, 8'h00, 1'b1);
    run_vec("v7f_00", 8'h7F, 8'h00, 1'b1);
    run_vec("vab_ba", 8'hAB, 8'hBA, 1'b1);

    // Mid-cycle asynchronous reset while s = 0x66.
    @(negedge clk);
    chk("pre_rst_s", {56'd0, s}, 64'h66);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", '0);
    a   = 8'h23;
    b   = 8'h32;
    cin = 1'b1;
    #1;
    rst_n = 1'b1;
    #1;
    check_out("rst_hold", '0);
    @(posedge clk);
    #1;
    check_out("post_rst", model(8'h23, 8'h32, 1'b1));

    // Back-to-back random vectors: each negedge checks the previous vector.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (i > 0) check_out("rnd", exp_prev);
      a        = N'($urandom);
      b        = N'($urandom);
      cin      = 1'($urandom);
      exp_prev = model(a, b, cin);
    end
    @(negedge clk);
    check_out("rnd_last", exp_prev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nbit_rca

// File: doc/nbit_rca.md
# nbit_rca

Parameterised N-bit ripple-carry adder with a registered result stage. It adds two N-bit operands plus a carry-in through a chain of N one-bit full adders, then captures the sum and carry-out in output registers on the clock edge. It is a datapath leaf block for any unit that needs a simple, area-minimal adder with one cycle of latency.

## Interface
- `N`, default 8: operand and sum width in bits; legal range 1 to 64.
- `clk`  input  1: rising-edge clock for all registers.
- `rst_n`  input  1: asynchronous, active-low reset.
- `a`  input  N: operand A, unsigned or two's-complement.
- `b`  input  N: operand B.
- `cin`  input  1: carry into bit 0.
- `s`  output  N: registered sum, `(a + b + cin) mod 2^N`.
- `cout`  output  1: registered carry out of bit N-1.
- `ovf`  output  1: registered signed overflow. Present only when `NBIT_RCA_OVF_EN` is defined.

## Operation
- Combinational core is a strict ripple chain, generated as N full-adder instances.
  - `c[0] = cin`.
  - For each i: `sum[i] = a[i] ^ b[i] ^ c[i]`.
  - `c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i])`.
- Carry-lookahead, prefix networks and `+` operator inference are not permitted.
- Registered result: `s <= sum[N-1:0]`, `cout <= c[N]`.
- Arithmetic identity: `{cout, s} == a + b + cin`, computed at N+1 bits with no truncation of the carry.
- Signed overflow (when enabled): `ovf <= c[N] ^ c[N-1]`.
  - For N = 1, this is `c[1] ^ cin`.
- No enable and no handshake. A new operation is accepted every clock.
- No X-propagation masking. X on an input gives X in the dependent outputs.

## Timing
- Latency is 1 cycle. Inputs are sampled at a rising `clk` edge, and the result is visible after that same edge.
- Throughput is one addition per cycle.
- Reset:
  - While `rst_n` is low, `s = 0`, `cout = 0` and `ovf = 0`, asynchronously and independent of `clk`.
  - Assertion mid-operation discards any pending result immediately.
- Reset release: the first rising edge with `rst_n` high captures the inputs present at that edge.
- Critical path is the N-stage carry ripple from `a[0]`/`b[0]`/`cin` to `c[N]`. It must close within one `clk` period at the target N.
- Wrap-around: the all-ones sum plus carry wraps `s` to 0 with `cout = 1`, with no other side effect.

## Configuration
- Macro `NBIT_RCA_OVF_EN`.
- Defined: the `ovf` port and its register exist, behaving as specified above.
- Not defined: the `ovf` port and register are absent. All other behaviour is identical.

## Structure
- Shared package `nbit_rca_pkg`:
  - Constant `NBIT_RCA_DEFAULT_W = 8`.
  - Constant `NBIT_RCA_MAX_W = 64`.
  - Typedef for the N+1-bit internal carry vector.
- Sub-module `rca_full_adder`:
  - Ports: `a`, `b`, `ci` inputs; `s`, `co` outputs. Purely combinational.
  - Instantiated N times in a generate loop.
- Top level: elaboration-time check that `1 <= N <= 64`, plus the output register process.

## Test plan
All cases use N = 8 and `cin = 1`, and check outputs one cycle after applying inputs.
- `a = 0x23`, `b = 0x32` -> `s = 0x56`, `cout = 0`, `ovf = 0`.
- `a = 0xAB`, `b = 0x00` -> `s = 0xAC`, `cout = 0`, `ovf = 0`.
- `a = 0xAB`, `b = 0xBA` -> `s = 0x66`, `cout = 1`, `ovf = 1`.
- Full ripple and positive overflow:
  - `a = 0xFF`, `b = 0x00` -> `s = 0x00`, `cout = 1`, `ovf = 0`.
  - `a = 0x7F`, `b = 0x00` -> `s = 0x80`, `cout = 0`, `ovf = 1`.
- Reset: drive `rst_n` low between clock edges while `s = 0x66` -> `s`, `cout` and `ovf` read 0 before the next edge. After release, the first edge captures the current inputs.
- Random: 10,000 back-to-back random `a`/`b`/`cin` vectors -> each cycle `{cout, s}` equals the 9-bit `a + b + cin` of the previous cycle.
